// File: rtl/car_voltage_pkg.sv
// Shared constants and FSM state type for the car voltage poller.
package car_voltage_pkg;
  localparam int ADC_W       = 12;
  localparam int RSP_TIMEOUT = 255;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2,
    ACCUM    = 2'd3
  } state_e;
endpackage

// File: rtl/car_voltage_poller_if.sv
// Avalon-MM read-only master bus towards the ADC register slave.
// Handshake: a read is accepted on the rising edge where avm_read=1 and
// avm_waitrequest=0; address and read are held stable while stalled; each
// accepted read is answered by exactly one avm_readdatavalid strobe.
interface car_voltage_poller_if;
  logic [1:0]  avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic        avm_readdatavalid;
  logic [31:0] avm_readdata;

  modport master (
    output avm_address, avm_read,
    input  avm_waitrequest, avm_readdatavalid, avm_readdata
  );

  modport slave (
    input  avm_address, avm_read,
    output avm_waitrequest, avm_readdatavalid, avm_readdata
  );
endinterface

// File: rtl/car_voltage_tick.sv
// Poll-rate divider: counts 0..POLL_DIV-1 while enabled, pulses tick on wrap.
module car_voltage_tick #(
  parameter int POLL_DIV = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  output logic tick
);
  localparam int CNT_W = $clog2(POLL_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrap;

  always_comb begin
    wrap  = (cnt_q == CNT_W'(POLL_DIV - 1));
    cnt_d = cnt_q + 1'b1;
    if (!enable || wrap) begin
      cnt_d = '0;
    end
    tick = enable && wrap;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/car_voltage_poller.sv
// Periodically reads the ADC over Avalon-MM, averages 2^AVG_LOG2 samples and
// flags undervoltage with hysteresis; a missing response sets a sticky error.
module car_voltage_poller
  import car_voltage_pkg::*;
#(
  parameter int               POLL_DIV   = 50000,
  parameter int               AVG_LOG2   = 3,
  parameter logic [ADC_W-1:0] LOW_THRESH = 12'd2900,
  parameter logic [ADC_W-1:0] LOW_HYST   = 12'd64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  car_voltage_poller_if.master avm,
  output logic [ADC_W-1:0]     avg_voltage,
  output logic                 avg_valid,
  output logic                 low_voltage,
  output logic                 timeout_err,
  output state_e               dbg_state
);
  localparam int ACC_W = ADC_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [ADC_W:0] CLEAR_LVL = {1'b0, LOW_THRESH} + {1'b0, LOW_HYST};

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ADC_W-1:0] sample_q, sample_d;
  logic [7:0]       tmo_q, tmo_d;
  logic             drop_q, drop_d;
  logic [ADC_W-1:0] avg_q, avg_d;
  logic             avg_valid_q, avg_valid_d;
  logic             low_q, low_d;
  logic             tmo_err_q, tmo_err_d;
  logic             tick;
  logic             unused_rdata;

  car_voltage_tick #(.POLL_DIV(POLL_DIV)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .tick    (tick)
  );

  assign unused_rdata    = ^avm.avm_readdata[31:ADC_W];
  assign avm.avm_address = 2'd0;
  assign avm.avm_read    = (state_q == REQ);
  assign avg_voltage     = avg_q;
  assign avg_valid       = avg_valid_q;
  assign low_voltage     = low_q;
  assign timeout_err     = tmo_err_q;
  assign dbg_state       = state_q;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sample_d    = sample_q;
    tmo_d       = tmo_q;
    drop_d      = drop_q;
    avg_d       = avg_q;
    avg_valid_d = 1'b0;
    low_d       = low_q;
    tmo_err_d   = tmo_err_q;

    case (state_q)
      IDLE: begin
        drop_d = 1'b0;
        if (!enable) begin
          acc_d = '0;
          cnt_d = '0;
        end
        if (tick && enable) begin
          state_d = REQ;
        end
      end
      REQ: begin
        // Once issued the read must finish; remember to discard its sample.
        if (!enable) drop_d = 1'b1;
        if (!avm.avm_waitrequest) begin
          tmo_d   = '0;
          state_d = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (!enable) drop_d = 1'b1;
        if (avm.avm_readdatavalid) begin
          sample_d = avm.avm_readdata[ADC_W-1:0];
          state_d  = ACCUM;
        end else if (tmo_q == 8'(RSP_TIMEOUT - 1)) begin
          tmo_err_d = 1'b1;
          acc_d     = '0;
          cnt_d     = '0;
          state_d   = IDLE;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      ACCUM: begin
        if (drop_q) begin
          acc_d = '0;
          cnt_d = '0;
        end else begin
          acc_d = acc_q + ACC_W'(sample_q);
          cnt_d = cnt_q + 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A full set always completes in ACCUM, so this fires in the following IDLE.
    if (cnt_q == CNT_W'(1 << AVG_LOG2)) begin
      avg_d       = ADC_W'(acc_q >> AVG_LOG2);
      avg_valid_d = 1'b1;
      acc_d       = '0;
      cnt_d       = '0;
      if (avg_d < LOW_THRESH) begin
        low_d = 1'b1;
      end else if ({1'b0, avg_d} >= CLEAR_LVL) begin
        low_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      sample_q    <= '0;
      tmo_q       <= '0;
      drop_q      <= 1'b0;
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
      low_q       <= 1'b0;
      tmo_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sample_q    <= sample_d;
      tmo_q       <= tmo_d;
      drop_q      <= drop_d;
      avg_q       <= avg_d;
      avg_valid_q <= avg_valid_d;
      low_q       <= low_d;
      tmo_err_q   <= tmo_err_d;
    end
  end
endmodule

// File: tb/tb_car_voltage_poller.sv
// Directed bench for car_voltage_poller: batch table plus stall, timeout,
// enable-drop and mid-transaction reset sequences against a scripted slave.
module tb_car_voltage_poller;
  import car_voltage_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [11:0] avg_voltage;
  logic        avg_valid;
  logic        low_voltage;
  logic        timeout_err;
  state_e      dbg_state;

  car_voltage_poller_if bus ();

  car_voltage_poller #(
    .POLL_DIV (16),
    .AVG_LOG2 (3)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .avm         (bus.master),
    .avg_voltage (avg_voltage),
    .avg_valid   (avg_valid),
    .low_voltage (low_voltage),
    .timeout_err (timeout_err),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- scripted Avalon slave ----------------
  logic [11:0] samp_q[$];
  logic [11:0] exp_q[$];
  int          slv_wait = 1;
  int          slv_lat = 0;
  bit          slv_silent = 1'b0;
  bit          chk_stall = 1'b1;
  bit          chk_period = 1'b0;
  int unsigned last_start = 0;
  int unsigned acc_cyc = 0;
  int          rsp_cnt = 0;
  int          avg_pulses = 0;

  always @(negedge clk) if (avg_valid === 1'b1) avg_pulses++;

  initial begin : slave
    logic [11:0] s;
    bus.avm_waitrequest   = 1'b1;
    bus.avm_readdatavalid = 1'b0;
    bus.avm_readdata      = '0;
    forever begin
      @(negedge clk);
      if (bus.avm_read === 1'b1) begin
        if (chk_period && last_start != 0) check("read_period", cyc - last_start, 16);
        last_start = cyc;
        for (int i = 0; i < slv_wait; i++) begin
          if (chk_stall) begin
            check("stall_read", {31'd0, bus.avm_read}, 1);
            check("stall_addr", {30'd0, bus.avm_address}, 0);
          end
          @(negedge clk);
        end
        bus.avm_waitrequest = 1'b0;
        @(negedge clk);
        bus.avm_waitrequest = 1'b1;
        acc_cyc = cyc;
        if (chk_stall) check("read_drop", {31'd0, bus.avm_read}, 0);
        if (!slv_silent) begin
          repeat (slv_lat) @(negedge clk);
          s = (samp_q.size() > 0) ? samp_q.pop_front() : 12'd0;
          bus.avm_readdatavalid = 1'b1;
          bus.avm_readdata      = {20'hA5C3F, s};
          @(negedge clk);
          bus.avm_readdatavalid = 1'b0;
          rsp_cnt++;
        end
      end
    end
  end

  // ---------------- driver / scoreboard tasks ----------------
  task automatic push_batch(input logic [11:0] base, input logic [11:0] step, input int n);
    for (int i = 0; i < n; i++) samp_q.push_back(base + 12'(i) * step);
  endtask

  task automatic wait_avg(input string nm, input logic [11:0] exp_avg, input logic exp_low,
                          input int budget);
    logic [11:0] e;
    int n = 0;
    exp_q.push_back(exp_avg);
    while (avg_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    e = exp_q.pop_front();
    if (avg_valid !== 1'b1) begin
      check({nm, "_no_avg_valid"}, 0, 1);
    end else begin
      check({nm, "_avg"}, {20'd0, avg_voltage}, {20'd0, e});
      check({nm, "_low"}, {31'd0, low_voltage}, {31'd0, exp_low});
      @(negedge clk);
      check({nm, "_pulse_len"}, {31'd0, avg_valid}, 0);
    end
  endtask

  task automatic wait_rsp(input int target, input int budget);
    int n = 0;
    while (rsp_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("rsp_count", rsp_cnt, target);
  endtask

  task automatic wait_state(input state_e st, input int budget);
    int n = 0;
    while (dbg_state != st && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("reach_state", {30'd0, dbg_state}, {30'd0, st});
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [11:0] base;
    logic [11:0] step;
    logic [11:0] exp_avg;
    logic        exp_low;
  } vec_t;

  vec_t vecs[12];

  initial begin : main
    int base_rsp;
    int n;
    vecs[0]  = '{12'd3000, 12'd0, 12'd3000, 1'b0};
    vecs[1]  = '{12'd2800, 12'd0, 12'd2800, 1'b1};
    vecs[2]  = '{12'd2950, 12'd0, 12'd2950, 1'b1};
    vecs[3]  = '{12'd2964, 12'd0, 12'd2964, 1'b0};
    vecs[4]  = '{12'd0,    12'd1, 12'd3,    1'b1};
    vecs[5]  = '{12'd2963, 12'd0, 12'd2963, 1'b1};
    vecs[6]  = '{12'd2964, 12'd0, 12'd2964, 1'b0};
    vecs[7]  = '{12'd2899, 12'd0, 12'd2899, 1'b1};
    vecs[8]  = '{12'd2900, 12'd0, 12'd2900, 1'b1};
    vecs[9]  = '{12'd2964, 12'd0, 12'd2964, 1'b0};
    vecs[10] = '{12'd2000, 12'd3, 12'd2010, 1'b1};
    vecs[11] = '{12'd4095, 12'd0, 12'd4095, 1'b0};

    // reset state
    repeat (5) @(negedge clk);
    check("rst_read",    {31'd0, bus.avm_read}, 0);
    check("rst_addr",    {30'd0, bus.avm_address}, 0);
    check("rst_avg",     {20'd0, avg_voltage}, 0);
    check("rst_valid",   {31'd0, avg_valid}, 0);
    check("rst_low",     {31'd0, low_voltage}, 0);
    check("rst_timeout", {31'd0, timeout_err}, 0);
    check("rst_state",   {30'd0, dbg_state}, {30'd0, IDLE});
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check("disabled_no_read", {31'd0, bus.avm_read}, 0);

    // table-driven batches
    enable = 1'b1;
    for (int v = 0; v < 12; v++) begin
      chk_period = (v == 0);
      push_batch(vecs[v].base, vecs[v].step, 8);
      wait_avg($sformatf("vec%0d", v), vecs[v].exp_avg, vecs[v].exp_low, 400);
    end
    chk_period = 1'b0;

    // long waitrequest stall on every read
    slv_wait = 40;
    push_batch(12'd1000, 12'd0, 8);
    wait_avg("stall40", 12'd1000, 1'b1, 2000);
    slv_wait = 1;

    // response timeout discards a partial average
    base_rsp = rsp_cnt;
    push_batch(12'd500, 12'd0, 3);
    wait_rsp(base_rsp + 3, 400);
    slv_silent = 1'b1;
    n = 0;
    while (timeout_err !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("timeout_set", {31'd0, timeout_err}, 1);
    check("timeout_cycles", cyc - acc_cyc, 255);
    check("timeout_idle", {30'd0, dbg_state}, {30'd0, IDLE});
    slv_silent = 1'b0;
    push_batch(12'd2000, 12'd0, 8);
    wait_avg("after_timeout", 12'd2000, 1'b1, 400);
    check("timeout_sticky", {31'd0, timeout_err}, 1);

    // enable drop during WAIT_RSP after 5 samples
    base_rsp = rsp_cnt;
    push_batch(12'd100, 12'd0, 6);
    wait_rsp(base_rsp + 5, 400);
    slv_lat = 6;
    wait_state(WAIT_RSP, 100);
    enable = 1'b0;
    n = avg_pulses;
    wait_rsp(base_rsp + 6, 100);
    repeat (100) @(negedge clk);
    check("drop_no_avg", avg_pulses, n);
    check("drop_idle", {30'd0, dbg_state}, {30'd0, IDLE});
    slv_lat = 0;
    enable = 1'b1;
    push_batch(12'd3500, 12'd0, 8);
    wait_avg("reenable", 12'd3500, 1'b0, 400);

    // reset in the middle of a stalled read; its late response must be ignored
    chk_stall = 1'b0;
    slv_wait = 30;
    samp_q.push_back(12'd4000);
    wait_state(REQ, 100);
    reset_n = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    check("midrst_read", {31'd0, bus.avm_read}, 0);
    check("midrst_state", {30'd0, dbg_state}, {30'd0, IDLE});
    check("midrst_timeout_clr", {31'd0, timeout_err}, 0);
    check("midrst_avg", {20'd0, avg_voltage}, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (50) @(negedge clk);
    check("late_rsp_seen", {31'd0, 1'(samp_q.size() == 0)}, 1);
    slv_wait = 1;
    chk_stall = 1'b1;
    enable = 1'b1;
    push_batch(12'd1234, 12'd0, 8);
    wait_avg("after_reset", 12'd1234, 1'b1, 400);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
